// File: rtl/reorder_buffer.sv
//==============================================================================
// Module      : reorder_buffer
// Description : Circular in-order reorder buffer. It allocates entries at the
//               tail, captures CDB results, and retires completed entries from
//               the head. Defining ROB_SQUASH_EN adds a flush input, squash.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module reorder_buffer #(
    parameter int ROB_DEPTH = 8,
    parameter int REG_LEN   = 5,
    parameter int XLEN      = 32,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
`ifdef ROB_SQUASH_EN
    input  logic               squash,
`endif
    input  logic               dispatch_valid,
    input  logic [REG_LEN-1:0] dispatch_dest,
    output logic               dispatch_ready,
    output logic [TAG_W-1:0]   dispatch_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [XLEN-1:0]    cdb_value,
    input  logic [TAG_W-1:0]   rs1_tag,
    input  logic [TAG_W-1:0]   rs2_tag,
    output logic [XLEN-1:0]    rs1_value,
    output logic [XLEN-1:0]    rs2_value,
    output logic               rs1_done,
    output logic               rs2_done,
    output logic               retire,
    output logic [TAG_W-1:0]   head_idx,
    output logic [REG_LEN-1:0] retire_dest,
    output logic [XLEN-1:0]    retire_value,
    output logic               full,
    output logic               empty
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] complete_q, complete_d;
    logic [REG_LEN-1:0]   dest_q  [ROB_DEPTH];
    logic [REG_LEN-1:0]   dest_d  [ROB_DEPTH];
    logic [XLEN-1:0]      value_q [ROB_DEPTH];
    logic [XLEN-1:0]      value_d [ROB_DEPTH];
    logic [TAG_W-1:0]     head_q, head_d;
    logic [TAG_W-1:0]     tail_q, tail_d;
    logic [TAG_W:0]       count_q, count_d;
    logic                 alloc;

    assign full           = (count_q == DEPTH_CNT);
    assign empty          = (count_q == '0);
    assign dispatch_ready = ~full;
    assign dispatch_tag   = tail_q;
    assign head_idx       = head_q;
    assign retire         = busy_q[head_q] & complete_q[head_q];
    assign retire_dest    = dest_q[head_q];
    assign retire_value   = value_q[head_q];
    assign rs1_done       = busy_q[rs1_tag] & complete_q[rs1_tag];
    assign rs2_done       = busy_q[rs2_tag] & complete_q[rs2_tag];
    assign rs1_value      = value_q[rs1_tag];
    assign rs2_value      = value_q[rs2_tag];

    // A full ROB blocks dispatch even when the head retires this cycle.
    assign alloc = dispatch_valid & ~full;

    always_comb begin
        busy_d     = busy_q;
        complete_d = complete_q;
        dest_d     = dest_q;
        value_d    = value_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (cdb_valid && busy_q[cdb_tag]) begin
            complete_d[cdb_tag] = 1'b1;
            value_d[cdb_tag]    = cdb_value;
        end

        if (retire) begin
            busy_d[head_q]     = 1'b0;
            complete_d[head_q] = 1'b0;
            head_d             = head_q + TAG_W'(1);
        end

        // Applied last so a fresh allocation always starts incomplete.
        if (alloc) begin
            busy_d[tail_q]     = 1'b1;
            complete_d[tail_q] = 1'b0;
            dest_d[tail_q]     = dispatch_dest;
            tail_d             = tail_q + TAG_W'(1);
        end

        case ({alloc, retire})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
        endcase

`ifdef ROB_SQUASH_EN
        if (squash) begin
            busy_d     = '0;
            complete_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dest_q[i]  <= dest_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
//==============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. It runs directed
//               scenarios plus random traffic against a queue-based model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_reorder_buffer;

    localparam int DEPTH = 8;
    localparam int RL    = 5;
    localparam int XL    = 32;
    localparam int TW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          squash;
    logic          dispatch_valid;
    logic [RL-1:0] dispatch_dest;
    logic          dispatch_ready;
    logic [TW-1:0] dispatch_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [XL-1:0] cdb_value;
    logic [TW-1:0] rs1_tag, rs2_tag;
    logic [XL-1:0] rs1_value, rs2_value;
    logic          rs1_done, rs2_done;
    logic          retire;
    logic [TW-1:0] head_idx;
    logic [RL-1:0] retire_dest;
    logic [XL-1:0] retire_value;
    logic          full, empty;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    reorder_buffer #(.ROB_DEPTH(DEPTH), .REG_LEN(RL), .XLEN(XL)) dut (
        .clock          (clock),
        .reset          (reset),
`ifdef ROB_SQUASH_EN
        .squash         (squash),
`endif
        .dispatch_valid (dispatch_valid),
        .dispatch_dest  (dispatch_dest),
        .dispatch_ready (dispatch_ready),
        .dispatch_tag   (dispatch_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .rs1_tag        (rs1_tag),
        .rs2_tag        (rs2_tag),
        .rs1_value      (rs1_value),
        .rs2_value      (rs2_value),
        .rs1_done       (rs1_done),
        .rs2_done       (rs2_done),
        .retire         (retire),
        .head_idx       (head_idx),
        .retire_dest    (retire_dest),
        .retire_value   (retire_value),
        .full           (full),
        .empty          (empty)
    );

    // Reference model: program-order queue of live tags plus per-tag fields.
    logic [TW-1:0] order[$];
    logic [TW-1:0] m_tail;
    logic          m_done [DEPTH];
    logic [RL-1:0] m_dest [DEPTH];
    logic [XL-1:0] m_val  [DEPTH];

    function automatic bit m_busy(logic [TW-1:0] t);
        foreach (order[i]) if (order[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset;
        order.delete();
        m_tail = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_done[i] = 1'b0;
            m_dest[i] = '0;
            m_val[i]  = '0;
        end
    endtask

    task automatic model_edge;
        bit ret, alc;
        ret = (order.size() > 0) && m_done[order[0]];
        alc = dispatch_valid && (order.size() < DEPTH);
        if (cdb_valid && m_busy(cdb_tag)) begin
            m_done[cdb_tag] = 1'b1;
            m_val[cdb_tag]  = cdb_value;
        end
        if (ret) begin
            m_done[order[0]] = 1'b0;
            void'(order.pop_front());
        end
        if (alc) begin
            order.push_back(m_tail);
            m_done[m_tail] = 1'b0;
            m_dest[m_tail] = dispatch_dest;
            m_tail = m_tail + 3'd1;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        squash = 1'b0; dispatch_valid = 1'b0; dispatch_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        rs1_tag = '0; rs2_tag = '0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic dispatch_n(int n, int dest_base);
        for (int i = 0; i < n; i++) begin
            dispatch_valid = 1'b1; dispatch_dest = RL'(dest_base + i);
            tick();
        end
        dispatch_valid = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clock);
        n_checks++;
        if ({dispatch_ready, dispatch_tag, retire, head_idx, full, empty, rs1_done, rs2_done} !==
            {1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_flags: ready=%b tag=%0d retire=%b head=%0d full=%b empty=%b rsdone=%b%b expected 1 0 0 0 0 1 00",
                     dispatch_ready, dispatch_tag, retire, head_idx, full, empty, rs1_done, rs2_done);
        end
        n_checks++;
        if ({retire_dest, retire_value, rs1_value, rs2_value} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: dest=%0h val=%0h rs1=%0h rs2=%0h expected all 0",
                     retire_dest, retire_value, rs1_value, rs2_value);
        end
    endtask

    task automatic test_reset_mid_traffic;
        apply_reset();
        dispatch_n(3, 1);
        dispatch_valid = 1'b1; dispatch_dest = 5'd7;
        reset = 1'b1;
        tick();
        reset = 1'b0; dispatch_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({empty, head_idx, dispatch_tag, retire} !== {1'b1, 3'd0, 3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid_traffic: empty=%b head=%0d tag=%0d retire=%b expected 1 0 0 0",
                     empty, head_idx, dispatch_tag, retire);
        end
    endtask

    task automatic test_fill_and_overflow;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            dispatch_valid = 1'b1; dispatch_dest = RL'(i + 1);
            @(negedge clock);
            n_checks++;
            if (dispatch_tag !== 3'(i) || dispatch_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_tag: tag=%0d ready=%b expected %0d 1", dispatch_tag, dispatch_ready, i);
            end
            tick();
        end
        dispatch_dest = 5'd9;
        @(negedge clock);
        n_checks++;
        if ({full, dispatch_ready, dispatch_tag} !== {1'b1, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL full_flags: full=%b ready=%b tag=%0d expected 1 0 0", full, dispatch_ready, dispatch_tag);
        end
        tick();
        dispatch_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({full, empty, dispatch_tag, head_idx, retire} !== {1'b1, 1'b0, 3'd0, 3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL overflow_ignored: full=%b empty=%b tag=%0d head=%0d retire=%b expected 1 0 0 0 0",
                     full, empty, dispatch_tag, head_idx, retire);
        end
    endtask

    // Continues from a full ROB: head completes while dispatch is held.
    task automatic test_full_retire_blocked;
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'h55;
        tick();
        cdb_valid = 1'b0;
        dispatch_valid = 1'b1; dispatch_dest = 5'd20;
        @(negedge clock);
        n_checks++;
        if ({retire, dispatch_ready, retire_dest, retire_value} !== {1'b1, 1'b0, 5'd1, 32'h55}) begin
            n_errors++;
            $display("FAIL full_retire: retire=%b ready=%b dest=%0d val=%0h expected 1 0 1 55",
                     retire, dispatch_ready, retire_dest, retire_value);
        end
        tick();
        @(negedge clock);
        n_checks++;
        if ({full, dispatch_ready, dispatch_tag, head_idx, retire} !== {1'b0, 1'b1, 3'd0, 3'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL after_retire: full=%b ready=%b tag=%0d head=%0d retire=%b expected 0 1 0 1 0",
                     full, dispatch_ready, dispatch_tag, head_idx, retire);
        end
        tick();
        dispatch_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({full, dispatch_tag, head_idx} !== {1'b1, 3'd1, 3'd1}) begin
            n_errors++;
            $display("FAIL wrap_alloc: full=%b tag=%0d head=%0d expected 1 1 1", full, dispatch_tag, head_idx);
        end
    endtask

    task automatic test_inorder_retire;
        logic [RL-1:0] exp_dest [3];
        logic [XL-1:0] exp_val  [3];
        exp_dest = '{5'd1, 5'd2, 5'd3};
        exp_val  = '{32'hA0, 32'hA1, 32'hBEEF};
        apply_reset();
        dispatch_n(3, 1);
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 32'hBEEF;
        tick();
        cdb_tag = 3'd0; cdb_value = 32'hA0;
        @(negedge clock);
        n_checks++;
        if (retire !== 1'b0) begin
            n_errors++;
            $display("FAIL out_of_order: retire=%b expected 0", retire);
        end
        tick();
        cdb_tag = 3'd1; cdb_value = 32'hA1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if ({retire, head_idx, retire_dest, retire_value} !== {1'b1, 3'(i), exp_dest[i], exp_val[i]}) begin
                n_errors++;
                $display("FAIL inorder_retire_%0d: retire=%b head=%0d dest=%0d val=%0h expected 1 %0d %0d %0h",
                         i, retire, head_idx, retire_dest, retire_value, i, exp_dest[i], exp_val[i]);
            end
            tick();
            cdb_valid = 1'b0;
        end
        @(negedge clock);
        n_checks++;
        if ({retire, empty} !== 2'b01) begin
            n_errors++;
            $display("FAIL drained: retire=%b empty=%b expected 0 1", retire, empty);
        end
    endtask

    task automatic test_read_ports;
        apply_reset();
        dispatch_n(5, 1);
        rs1_tag = 3'd4; rs2_tag = 3'd3;
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 32'h12;
        @(negedge clock);
        n_checks++;
        if (rs1_done !== 1'b0) begin
            n_errors++;
            $display("FAIL rs1_no_bypass: done=%b expected 0", rs1_done);
        end
        tick();
        cdb_tag = 3'd6; cdb_value = 32'h77;
        @(negedge clock);
        n_checks++;
        if ({rs1_done, rs1_value, rs2_done} !== {1'b1, 32'h12, 1'b0}) begin
            n_errors++;
            $display("FAIL rs1_complete: done=%b val=%0h rs2done=%b expected 1 12 0", rs1_done, rs1_value, rs2_done);
        end
        tick();
        cdb_valid = 1'b0; rs2_tag = 3'd6;
        @(negedge clock);
        n_checks++;
        if ({rs2_done, rs2_value} !== {1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL cdb_idle_ignored: done=%b val=%0h expected 0 0", rs2_done, rs2_value);
        end
    endtask

`ifdef ROB_SQUASH_EN
    task automatic test_squash;
        apply_reset();
        dispatch_n(5, 1);
        squash = 1'b1; dispatch_valid = 1'b1; dispatch_dest = 5'd9;
        tick();
        squash = 1'b0; dispatch_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({empty, dispatch_tag, head_idx, retire} !== {1'b1, 3'd0, 3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL squash: empty=%b tag=%0d head=%0d retire=%b expected 1 0 0 0",
                     empty, dispatch_tag, head_idx, retire);
        end
    endtask
`endif

    task automatic test_random_traffic;
        logic [TW-1:0] pending[$];
        logic [TW-1:0] exp_head, t;
        bit            exp_ret;
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            dispatch_valid = ($urandom_range(0, 99) < 55);
            dispatch_dest  = RL'($urandom);
            rs1_tag = TW'($urandom); rs2_tag = TW'($urandom);
            pending.delete();
            foreach (order[i]) if (!m_done[order[i]]) pending.push_back(order[i]);
            cdb_valid = 1'b0; cdb_tag = '0; cdb_value = $urandom;
            if (pending.size() > 0 && $urandom_range(0, 99) < 50) begin
                cdb_valid = 1'b1;
                cdb_tag = pending[$urandom_range(0, pending.size() - 1)];
            end else if ($urandom_range(0, 99) < 15) begin
                t = TW'($urandom);
                if (!m_busy(t)) begin cdb_valid = 1'b1; cdb_tag = t; end
            end
            @(negedge clock);
            exp_head = m_tail - TW'(order.size());
            exp_ret  = (order.size() > 0) && m_done[order[0]];
            n_checks++;
            if ({dispatch_ready, full, empty, dispatch_tag, head_idx, retire} !==
                {order.size() < DEPTH, order.size() == DEPTH, order.size() == 0, m_tail, exp_head, exp_ret}) begin
                n_errors++;
                $display("FAIL rand_ctrl cyc%0d: ready=%b full=%b empty=%b tag=%0d head=%0d retire=%b expected size=%0d tail=%0d head=%0d retire=%b",
                         cyc, dispatch_ready, full, empty, dispatch_tag, head_idx, retire,
                         order.size(), m_tail, exp_head, exp_ret);
            end
            if (exp_ret) begin
                n_checks++;
                if ({retire_dest, retire_value} !== {m_dest[exp_head], m_val[exp_head]}) begin
                    n_errors++;
                    $display("FAIL rand_retire cyc%0d: dest=%0d val=%0h expected %0d %0h",
                             cyc, retire_dest, retire_value, m_dest[exp_head], m_val[exp_head]);
                end
            end
            n_checks++;
            if ({rs1_done, rs1_value, rs2_done, rs2_value} !==
                {m_busy(rs1_tag) && m_done[rs1_tag], m_val[rs1_tag],
                 m_busy(rs2_tag) && m_done[rs2_tag], m_val[rs2_tag]}) begin
                n_errors++;
                $display("FAIL rand_rs cyc%0d: rs1 %b/%0h rs2 %b/%0h expected %b/%0h %b/%0h", cyc,
                         rs1_done, rs1_value, rs2_done, rs2_value,
                         m_busy(rs1_tag) && m_done[rs1_tag], m_val[rs1_tag],
                         m_busy(rs2_tag) && m_done[rs2_tag], m_val[rs2_tag]);
            end
            @(posedge clock);
            model_edge();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_reset_mid_traffic();
        test_fill_and_overflow();
        test_full_retire_blocked();
        test_inorder_retire();
        test_read_ports();
`ifdef ROB_SQUASH_EN
        test_squash();
`endif
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
